fb_page_arbiter: RTL and testbench
==================================

# fb_page_arbiter

Double-buffered frame-buffer arbiter sitting between the 640x480 VGA timing/scan block, a pixel writer (render or camera path) and one single-port 12-bit frame-buffer RAM holding two pages. Display reads always win the RAM port. Writer traffic is absorbed by a small FIFO and drained in cycles the display leaves free, mainly horizontal and vertical blanking. A page-swap state machine flips front and back pages on a VSYNC falling edge once the writer has finished a frame and all of its data has reached memory.

## Interface
- ADDR_W, 19, pixel address width (one page, 307200 pixels used)
- DATA_W, 12, pixel width {B[11:8],G[7:4],R[3:0]}
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

- clk  in  1  pixel clock
- rstn  in  1  asynchronous, active-low reset
- disp_req  in  1  display read strobe, one per active pixel
- disp_addr  in  ADDR_W  display pixel address
- disp_vsync  in  1  display VSYNC, active low
- disp_data  out  DATA_W  read data; equals mem_rdata
- wr_valid  in  1  writer word valid
- wr_ready  out  1  FIFO accepts word this cycle
- wr_addr  in  ADDR_W  writer pixel address
- wr_data  in  DATA_W  writer pixel
- wr_frame_done  in  1  pulse: last word of a frame (qualified alone or with a word)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W+1  {page, pixel address}
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- front_page  out  1  page currently displayed
- frame_swapped  out  1  one-cycle pulse after a swap
- done_err  out  1  sticky: wr_frame_done received while a swap was pending

## Operation
- Write FIFO: push when wr_valid && wr_ready, storing {wr_addr, wr_data}. wr_ready = !full && state==IDLE (combinational).
- RAM port, combinational each cycle:
  - disp_req=1: mem_en=1, mem_we=0, mem_addr={front_page, disp_addr}.
  - else, FIFO non-empty: mem_en=1, mem_we=1, mem_addr={~front_page, head addr}, mem_wdata=head data; pop head.
  - else: mem_en=0, mem_we=0.
- Pop and push in the same cycle are legal. Occupancy is unchanged.
- Swap FSM:
  - IDLE: wr_frame_done → PEND. If a word is accepted in the same cycle, it belongs to the finishing frame.
  - PEND: wr_ready=0. On a VSYNC falling edge (registered disp_vsync 1→0) with the FIFO empty → SWAP. With the FIFO non-empty at the edge, stay in PEND and wait for the next edge.
  - SWAP: toggle front_page, pulse frame_swapped, → IDLE. Lasts one cycle.
- A wr_frame_done in PEND or SWAP is ignored and sets done_err. done_err is cleared only by reset.
- The FIFO drains during PEND, so every FIFO entry always targets the page that is current back.

## Timing
- Reset values: front_page=0, frame_swapped=0, done_err=0, FSM=IDLE, FIFO empty (wr_ready=1), vsync edge register=1, mem_en=mem_we=0 (no requests).
- Read latency: disp_data is valid one cycle after disp_req.
- Write latency: a word accepted at cycle N reaches the RAM no earlier than N+1, and only on a cycle with disp_req=0.
- Swap: edge detected at cycle E (prev=1, current=0 sampled) → SWAP state at E+1 → front_page toggled and frame_swapped=1 at E+2.
- wr_ready returns to 1 in the cycle after SWAP.
- A reset mid-frame discards FIFO contents and pending swaps.

## Test plan
- Reset release, no traffic: front_page=0, wr_ready=1, mem_en=0, done_err=0.
- Contention: disp_req=1 for 640 cycles while the writer pushes 6 words. Required: wr_ready=1 for 4 pushes then 0. No RAM write occurs while disp_req=1. All 6 words are written to page 1 after disp_req drops, in order, with correct addr/data. Every read uses page 0 and its data appears one cycle later.
- Swap: write 4 words, then wr_frame_done. Required: wr_ready=0. FIFO drains in blanking. On the next VSYNC fall, front_page becomes 1 two cycles after the edge, with a single frame_swapped pulse. Subsequent writes go to page 0.
- Deferred swap: wr_frame_done while disp_req stays high across a VSYNC fall and the FIFO is non-empty. Required: no swap at that edge. The swap occurs at the following edge once the FIFO is empty.
- Second wr_frame_done during PEND: done_err=1, and only one swap occurs.
- Assert rstn low while PEND with a full FIFO: all reset values are restored. No stale write reaches the RAM after release.

Source files
------------

// File: rtl/fb_page_arbiter.sv
// fb_page_arbiter: double-buffered frame-buffer port arbiter with display-priority reads,
// a write FIFO drained in display-idle cycles, and a VSYNC-synchronised page swap.
module fb_page_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_vsync,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              front_page,
  output logic              frame_swapped,
  output logic              done_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PEND, SWAP} state_t;
  state_t r_state, w_next;
  logic [ADDR_W+DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PW:0] r_wp, r_rp;
  logic r_vs, r_front, r_swapped, r_err;
  logic w_empty, w_full, w_push, w_pop, w_edge;
  logic [ADDR_W+DATA_W-1:0] w_head;
  assign w_empty = r_wp == r_rp;
  assign w_full = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_head = r_fifo[r_rp[PW-1:0]];
  assign w_push = wr_valid && wr_ready;
  assign w_pop = !disp_req && !w_empty;
  assign w_edge = r_vs && !disp_vsync;
  assign wr_ready = !w_full && r_state == IDLE;
  assign disp_data = mem_rdata;
  assign front_page = r_front;
  assign frame_swapped = r_swapped;
  assign done_err = r_err;
  always_comb begin
    mem_en = disp_req || !w_empty;
    mem_we = !disp_req && !w_empty;
    mem_addr = disp_req ? {r_front, disp_addr} : {~r_front, w_head[ADDR_W+DATA_W-1:DATA_W]};
    mem_wdata = w_head[DATA_W-1:0];
  end
  // only swap once every word of the finished frame is already in the back page
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (wr_frame_done ? PEND : IDLE) :
             r_state == PEND ? ((w_edge && w_empty) ? SWAP : PEND) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_vs <= 1'b1;
      r_front <= 1'b0;
      r_swapped <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wp <= r_wp + (PW+1)'(w_push);
      r_rp <= r_rp + (PW+1)'(w_pop);
      r_vs <= disp_vsync;
      r_front <= r_front ^ (r_state == SWAP);
      r_swapped <= r_state == SWAP;
      r_err <= r_err | (wr_frame_done && r_state != IDLE);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp[PW-1:0]] <= {wr_addr, wr_data};
  end
endmodule

// File: tb/tb_fb_page_arbiter.sv
// tb_fb_page_arbiter: directed and random stimulus against a queue-based frame-buffer model.
module tb_fb_page_arbiter;
  logic clk = 0, rstn = 0;
  logic disp_req = 0, disp_vsync = 1, wr_valid = 0, wr_frame_done = 0;
  logic [18:0] disp_addr = 0, wr_addr = 0;
  logic [11:0] wr_data = 0, disp_data, mem_wdata, mem_rdata = 0;
  logic wr_ready, mem_en, mem_we, front_page, frame_swapped, done_err;
  logic [19:0] mem_addr;
  fb_page_arbiter dut (
    .clk(clk), .rstn(rstn), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_vsync(disp_vsync), .disp_data(disp_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .front_page(front_page), .frame_swapped(frame_swapped), .done_err(done_err)
  );
  always #5 clk = ~clk;
  logic [11:0] bram [logic [19:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) bram[mem_addr] = mem_wdata;
    else if (mem_en) mem_rdata <= bram.exists(mem_addr) ? bram[mem_addr] : 12'h0;
  end
  logic [30:0] exp_q [$];
  logic [11:0] mmem [logic [19:0]];
  int m_hd = 0, rd_idx = 0, errs = 0, checks = 0, nacc = 0;
  bit m_front = 0, m_pend = 0, m_swap = 0, m_pulse = 0, m_err = 0, m_prev_vs = 1;
  bit m_rd_pend = 0, last_acc = 0;
  logic [11:0] m_rd_exp = 0;
  function automatic bit exp_ready();
    return (exp_q.size() - m_hd < 4) && !m_pend && !m_swap;
  endfunction
  always @(posedge clk) begin
    if (!rstn) begin
      m_front = 0; m_pend = 0; m_swap = 0; m_pulse = 0; m_err = 0; m_prev_vs = 1;
      m_rd_pend = 0; m_hd = exp_q.size();
    end else begin
      automatic bit edge_ = m_prev_vs && !disp_vsync;
      automatic bit rdy = exp_ready();
      automatic bit old_pend = m_pend, old_swap = m_swap;
      automatic int cnt = exp_q.size() - m_hd;
      automatic logic [19:0] k = {m_front, disp_addr};
      m_rd_pend = disp_req;
      if (disp_req) m_rd_exp = mmem.exists(k) ? mmem[k] : 12'h0;
      else if (cnt > 0) begin
        mmem[{~m_front, exp_q[m_hd][30:12]}] = exp_q[m_hd][11:0];
        m_hd++;
      end
      if (wr_valid && rdy) exp_q.push_back({wr_addr, wr_data});
      m_pulse = old_swap;
      if (old_swap) m_front = !m_front;
      m_swap = old_pend && edge_ && cnt == 0;
      if (m_swap) m_pend = 0;
      if (wr_frame_done) begin
        if (!old_pend && !old_swap) m_pend = 1;
        else m_err = 1;
      end
      m_prev_vs = disp_vsync;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_front", 32'(front_page), 0);
      chk("rst_swapped", 32'(frame_swapped), 0);
      chk("rst_done_err", 32'(done_err), 0);
      chk("rst_mem_en", {30'd0, mem_en, mem_we}, 0);
      rd_idx = exp_q.size();
    end else begin
      chk("wr_ready", 32'(wr_ready), 32'(exp_ready()));
      chk("front_page", 32'(front_page), 32'(m_front));
      chk("frame_swapped", 32'(frame_swapped), 32'(m_pulse));
      chk("done_err", 32'(done_err), 32'(m_err));
      if (disp_req) begin
        chk("rd_en", {30'd0, mem_en, mem_we}, 2);
        chk("rd_addr", 32'(mem_addr), 32'({m_front, disp_addr}));
      end else if (exp_q.size() - m_hd > 0) chk("wr_en", {30'd0, mem_en, mem_we}, 3);
      else chk("idle_en", 32'(mem_en), 0);
      if (mem_en && mem_we) begin
        chk("wr_has_entry", 32'(rd_idx < exp_q.size()), 1);
        if (rd_idx < exp_q.size()) begin
          chk("wr_addr", 32'(mem_addr), 32'({~m_front, exp_q[rd_idx][30:12]}));
          chk("wr_data", 32'(mem_wdata), 32'(exp_q[rd_idx][11:0]));
          rd_idx++;
        end
      end
      if (m_rd_pend) chk("rd_data", 32'(disp_data), 32'(m_rd_exp));
    end
  end
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      last_acc = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (last_acc) begin
        nacc++;
        wr_addr = 19'($urandom % 64);
        wr_data = 12'($urandom);
      end
    end
  endtask
  task automatic push_words(input int n, input bit done_last);
    automatic int n0 = nacc;
    for (int k = 0; k < 100 && nacc - n0 < n; k++) begin
      wr_valid = 1;
      wr_frame_done = done_last && (nacc - n0 == n - 1);
      tick();
    end
    wr_valid = 0;
    wr_frame_done = 0;
  endtask
  task automatic pulse_done();
    wr_frame_done = 1;
    tick();
    wr_frame_done = 0;
  endtask
  task automatic vsync_fall();
    disp_vsync = 0;
    tick(3);
    disp_vsync = 1;
  endtask
  initial begin
    wr_addr = 19'($urandom % 64);
    wr_data = 12'($urandom);
    tick(3);
    rstn = 1;
    tick(4);
    begin
      automatic int n0 = nacc;
      for (int i = 0; i < 640; i++) begin
        disp_req = 1;
        disp_addr = 19'(i);
        wr_valid = nacc - n0 < 6;
        tick();
      end
      disp_req = 0;
      for (int i = 0; i < 10; i++) begin
        wr_valid = nacc - n0 < 6;
        tick();
      end
      wr_valid = 0;
    end
    push_words(4, 1);
    tick(5);
    vsync_fall();
    tick(5);
    push_words(3, 0);
    tick(3);
    disp_req = 1;
    push_words(3, 0);
    pulse_done();
    tick(3);
    pulse_done();
    vsync_fall();
    tick(5);
    disp_req = 0;
    tick(10);
    vsync_fall();
    tick(5);
    disp_req = 1;
    push_words(4, 0);
    pulse_done();
    tick(2);
    disp_req = 0;
    rstn = 0;
    tick(2);
    rstn = 1;
    tick(10);
    for (int c = 0; c < 4000; c++) begin
      disp_vsync = (c % 500) < 490;
      disp_req = ((c % 50) < 35) && ((c % 500) < 400);
      disp_addr = 19'($urandom % 64);
      wr_valid = 1'($urandom % 2);
      wr_frame_done = ($urandom % 200) == 0;
      tick();
    end
    disp_req = 0;
    wr_valid = 0;
    wr_frame_done = 0;
    tick(10);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
